i2s_adc_capture: RTL



---
 rtl/i2s_adc_capture.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_adc_capture.sv
// Deserialises left-justified I2S ADC samples and writes {sample, pad} words to a BRAM write port.
// Strobe/write lands 3 clk after the last bit's bclk rise is first sampled; no back-pressure, at most one write per sample.
module i2s_adc_capture #(
  parameter int SAMPLE_BITS = 24,
  parameter int DEPTH       = 30000,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrclk,
  input  logic                   i2s_adcdat,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic                   stereo,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_err,
  output logic                   sample_valid,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_right,
  output logic [ADDR_WIDTH-1:0]  bram_addrb,
  output logic [31:0]            bram_dinb,
  output logic [3:0]             bram_web,
  output logic                   bram_enb,
  output logic                   bram_clkb,
  output logic                   bram_rstb
);
  localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [4:0]    SB         = 5'(SAMPLE_BITS);
  localparam logic [FW-1:0] LAST_FRAME = FW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t state, state_n;
  logic [2:0] bclk_sr, lrclk_sr;
  logic [1:0] dat_sr;
  logic bclk_rise, lr_edge, lr_rise;
  logic [4:0] cnt, cnt_n;
  logic [SAMPLE_BITS-1:0] shreg, shreg_n, pend_dat;
  logic chan_right, chan_right_n, got_sample, err_set;
  logic pend_vld, pend_right;
  logic [WW-1:0] w, w_n;
  logic [FW-1:0] frame, frame_n;
  logic stop_q, stop_n, stereo_q, stereo_n, clr_err, wr, last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bclk_sr  <= '0;
      lrclk_sr <= '0;
      dat_sr   <= '0;
    end else begin
      bclk_sr  <= {bclk_sr[1:0], i2s_bclk};
      lrclk_sr <= {lrclk_sr[1:0], i2s_lrclk};
      dat_sr   <= {dat_sr[0], i2s_adcdat};
    end
  end

  assign bclk_rise = bclk_sr[1] & ~bclk_sr[2];
  assign lr_edge   = lrclk_sr[1] ^ lrclk_sr[2];
  assign lr_rise   = lrclk_sr[1] & ~lrclk_sr[2];

  // A channel edge is applied before a coincident bclk rise, so that rise carries the new MSB.
  always_comb begin
    cnt_n        = cnt;
    shreg_n      = shreg;
    chan_right_n = chan_right;
    got_sample   = 1'b0;
    err_set      = lr_edge && (cnt != 5'd0) && (cnt < SB);
    if (lr_edge) begin
      cnt_n        = '0;
      shreg_n      = '0;
      chan_right_n = ~lrclk_sr[1];
    end
    if (bclk_rise && (cnt_n < SB)) begin
      shreg_n    = {shreg_n[SAMPLE_BITS-2:0], dat_sr[1]};
      cnt_n      = cnt_n + 5'd1;
      got_sample = (cnt_n == SB);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      shreg      <= '0;
      chan_right <= 1'b0;
      pend_vld   <= 1'b0;
      pend_dat   <= '0;
      pend_right <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      chan_right <= chan_right_n;
      pend_vld   <= got_sample;
      if (got_sample) begin
        pend_dat   <= shreg_n;
        pend_right <= chan_right_n;
      end
      frame_err  <= (frame_err & ~clr_err) | err_set;
    end
  end

  always_comb begin
    state_n  = state;
    w_n      = w;
    frame_n  = frame;
    stop_n   = stop_q;
    stereo_n = stereo_q;
    clr_err  = 1'b0;
    last     = 1'b0;
    wr       = pend_vld && (state == CAPTURE) && (!pend_right || stereo_q);
    unique case (state)
      IDLE, DONE: begin
        if (start && !stop) begin
          state_n  = ARM;
          w_n      = '0;
          frame_n  = '0;
          stop_n   = 1'b0;
          stereo_n = stereo;
          clr_err  = 1'b1;
        end
      end
      ARM: begin
        if (stop) state_n = IDLE;
        else if (lr_rise) state_n = CAPTURE;
      end
      CAPTURE: begin
        if (stop) stop_n = 1'b1;
        if (wr) begin
          // A frame is finished by its left sample in mono and by its right sample in stereo.
          last = (frame == LAST_FRAME) && (pend_right || !stereo_q);
          if (last) begin
            w_n     = '0;
            frame_n = '0;
            if (!continuous) state_n = DONE;
          end else begin
            w_n = w + WW'(1);
            if (pend_right || !stereo_q) frame_n = frame + FW'(1);
          end
        end
        if (lr_rise && (stop_q || stop)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      w        <= '0;
      frame    <= '0;
      stop_q   <= 1'b0;
      stereo_q <= 1'b0;
    end else begin
      state    <= state_n;
      w        <= w_n;
      frame    <= frame_n;
      stop_q   <= stop_n;
      stereo_q <= stereo_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_right <= 1'b0;
      bram_enb     <= 1'b0;
      bram_web     <= '0;
      bram_addrb   <= '0;
      bram_dinb    <= '0;
    end else begin
      sample_valid <= pend_vld;
      bram_enb     <= wr;
      bram_web     <= wr ? 4'hF : 4'h0;
      if (pend_vld) begin
        sample_data  <= pend_dat;
        sample_right <= pend_right;
      end
      if (wr) begin
        bram_addrb <= {w, 2'b00};
        bram_dinb  <= 32'(pend_dat) << (32 - SAMPLE_BITS);
      end
    end
  end

  assign busy      = (state == ARM) || (state == CAPTURE);
  assign done      = (state == DONE);
  assign bram_clkb = clk;
  assign bram_rstb = 1'b0;
endmodule
